spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter CPOL, default 1, idle level of spi_sck (mode CPOL/CPHA=0, matching spicore POLARITY).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port select  input  1  peripheral selected by address decode.
REQ-005 SHALL have port rd  input  1  CPU read strobe.
REQ-006 SHALL have port we  input  4  CPU byte write mask; only we[0] acts.
REQ-007 SHALL have port addr  input  1  word offset: 0 data, 1 control/status.
REQ-008 SHALL have port data_in  input  32  CPU write data.
REQ-009 SHALL have port data_out  output  32  CPU read data, combinational from addr.
REQ-010 SHALL have port interrupt  output  1  level interrupt request.
REQ-011 SHALL have ports spi_sck, spi_ss (active low), spi_mosi  input  1 each  external master pins.
REQ-012 SHALL have ports spi_miso  output  1  and spi_miso_oe  output  1  (high while spi_ss low).

Function
REQ-013 SHALL pass spi_sck, spi_ss, spi_mosi through 2-flop synchronizers and detect edges in clk domain; clk >= 4x sck required.
REQ-014 SHALL run FSM IDLE -> SHIFT on synced spi_ss fall; SHIFT -> IDLE on synced spi_ss rise.
REQ-015 On IDLE->SHIFT and after each completed byte SHALL load shifter from tx_reg if tx_pending (clearing tx_pending), else 0xFF; spi_miso = shifter[7] (MSB first).
REQ-016 SHALL sample MOSI on leading sck edge, shift MISO on trailing edge; 3-bit bit counter wraps 7->0.
REQ-017 On 8th sample SHALL push rx byte; rx_valid high the following clk.
REQ-018 spi_ss rise mid-byte SHALL discard partial byte, no push, no tx_pending change.
REQ-019 Write addr 0 (select & we[0]) SHALL set tx_reg=data_in[7:0], tx_pending=1; same-cycle with a load, load uses old state, write becomes pending.
REQ-020 Read addr 0 SHALL return {24'b0, rx byte}; rd & select pops/clears it.
REQ-021 Read addr 1 SHALL return {27'b0, irq_en, busy(SHIFT), overrun, tx_pending, rx_valid}.
REQ-022 Write addr 1 SHALL set irq_en=data_in[4]; data_in[2]=1 clears overrun.
REQ-023 Push while holding full SHALL set overrun (storage behaviour per REQ-029/030).
REQ-024 Pop and push in same cycle SHALL keep rx_valid=1, store new byte, no overrun.
REQ-025 interrupt SHALL equal irq_en & (rx_valid | overrun).

Reset
REQ-026 reset SHALL force IDLE, bit counter 0, rx_valid/overrun/tx_pending/irq_en 0, tx_reg 0xFF, shifter 0xFF, spi_miso 1, spi_miso_oe 0, interrupt 0, synchronizers to idle levels (sck=CPOL, ss=1).
REQ-027 reset mid-transfer SHALL abort; SHIFT re-entered only on a fresh spi_ss fall.

Configuration
REQ-028 Macro SPI_SLAVE_RX_FIFO_EN selects rx storage.
REQ-029 Defined: 4-entry RX FIFO, rx_valid = not empty, push when full drops byte and sets overrun; status bits [7:5] = entry count (0-4).
REQ-030 Undefined: single holding register, push when full overwrites old byte and sets overrun; bits [7:5] read 0.

Structure
REQ-031 Package spi_slave_pkg SHALL hold register offsets, status bit indices, FIFO depth (4), idle MISO byte (0xFF), FSM state encoding.
REQ-032 Sub-module spi_slave_sync SHALL implement synchronizers and edge detection.

Verification
REQ-033 CPOL=1: CPU writes 0xA5, master sends 0x3C -> master receives 0xA5, rx byte 0x3C, rx_valid=1, tx_pending=0.
REQ-034 No tx write, master sends 2 bytes -> master receives 0xFF,0xFF; second push sets overrun (no FIFO) or count=2 (FIFO).
REQ-035 spi_ss raised after 5 bits -> rx_valid stays 0, next full byte 0x81 received correctly.
REQ-036 irq_en=1, byte 0x42 received -> interrupt high; rd addr 0 returns 0x42, interrupt low.
REQ-037 FIFO build: 5 bytes 0x01-0x05 without reads -> pops return 0x01-0x04, overrun=1; write addr1 bit2 clears it.
REQ-038 reset asserted mid-byte -> all outputs to REQ-026 values next cycle; transfer after new ss fall succeeds.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: register offsets, status bit indices, FIFO depth, idle MISO byte and FSM encoding for spi_slave
package spi_slave_pkg;
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;
  localparam int BIT_RX_VALID = 0;
  localparam int BIT_TX_PEND = 1;
  localparam int BIT_OVERRUN = 2;
  localparam int BIT_BUSY = 3;
  localparam int BIT_IRQ_EN = 4;
  localparam int BIT_COUNT = 5;
  localparam int FIFO_DEPTH = 4;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-flop synchronizers + edge detect (in clk, reset, spi_sck/ss/mosi; out sck_lead/trail, ss_fall/rise, mosi_s); ss_fall only after a real high is seen post-reset
module spi_slave_sync #(parameter logic CPOL = 1'b1) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic sck_lead,
  output logic sck_trail,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);
  logic [2:0] sck_q, sck_d, ss_q, ss_d;
  logic [1:0] mosi_q, mosi_d, vld_q, vld_d;
  logic armed_q, armed_d;
  always_comb begin
    sck_d = {sck_q[1:0], spi_sck};
    ss_d = {ss_q[1:0], spi_ss};
    mosi_d = {mosi_q[0], spi_mosi};
    vld_d = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ss_q[1]);
    sck_lead = (sck_q[2] == CPOL) & (sck_q[1] != CPOL);
    sck_trail = (sck_q[2] != CPOL) & (sck_q[1] == CPOL);
    ss_fall = armed_q & ss_q[2] & ~ss_q[1];
    ss_rise = ~ss_q[2] & ss_q[1];
    mosi_s = mosi_q[1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sck_q <= {3{CPOL}};
      ss_q <= '1;
      mosi_q <= '1;
      vld_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sck_q <= sck_d;
      ss_q <= ss_d;
      mosi_q <= mosi_d;
      vld_q <= vld_d;
      armed_q <= armed_d;
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: CPU-mapped SPI slave, CPHA=0 (ports clk, reset, select, rd, we, addr, data_in, data_out, interrupt, spi_sck/ss/mosi/miso/miso_oe); SPI_SLAVE_RX_FIFO_EN selects 4-deep rx FIFO
module spi_slave import spi_slave_pkg::*; #(parameter logic CPOL = 1'b1) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic        rd,
  input  logic [3:0]  we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        interrupt,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shifter_q, shifter_d, tx_reg_q, tx_reg_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic tx_pending_q, tx_pending_d, overrun_q, overrun_d, irq_en_q, irq_en_d;
  logic sck_lead, sck_trail, ss_fall, ss_rise, mosi_s;
  logic wr_data, wr_ctrl, pop, push, load, shift_en, ovr_set, rx_valid;
  logic [7:0] push_byte, rx_byte;
  logic [2:0] rx_count;
  logic unused_bits;
  assign unused_bits = ^{we[3:1], data_in[31:8]};
  spi_slave_sync #(.CPOL(CPOL)) u_sync (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .sck_lead(sck_lead), .sck_trail(sck_trail), .ss_fall(ss_fall), .ss_rise(ss_rise), .mosi_s(mosi_s)
  );
  always_comb begin
    wr_data = select & we[0] & (addr == ADDR_DATA);
    wr_ctrl = select & we[0] & (addr == ADDR_CTRL);
    pop = select & rd & (addr == ADDR_DATA);
    shift_en = (state_q == S_SHIFT) & ~ss_rise;
    push_byte = {rx_sh_q, mosi_s};
    push = shift_en & sck_lead & (cnt_q == 3'd7);
    load = ((state_q == S_IDLE) & ss_fall) | (shift_en & sck_trail & (cnt_q == 3'd0));
    state_d = (state_q == S_IDLE) ? (ss_fall ? S_SHIFT : S_IDLE) : (ss_rise ? S_IDLE : S_SHIFT);
    cnt_d = shift_en ? cnt_q + {2'b0, sck_lead} : 3'd0;
    rx_sh_d = (shift_en & sck_lead) ? push_byte[6:0] : rx_sh_q;
    shifter_d = load ? (tx_pending_q ? tx_reg_q : IDLE_BYTE) :
                (shift_en & sck_trail) ? {shifter_q[6:0], 1'b1} : shifter_q;
    tx_pending_d = wr_data | (tx_pending_q & ~load);
    tx_reg_d = wr_data ? data_in[7:0] : tx_reg_q;
    irq_en_d = wr_ctrl ? data_in[BIT_IRQ_EN] : irq_en_q;
    overrun_d = ovr_set | (overrun_q & ~(wr_ctrl & data_in[BIT_OVERRUN]));
  end
`ifdef SPI_SLAVE_RX_FIFO_EN
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic pop_ok, push_ok;
  always_comb begin
    pop_ok = pop & (count_q != 3'd0);
    push_ok = push & ((count_q != 3'(FIFO_DEPTH)) | pop_ok);
    ovr_set = push & ~push_ok;
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_byte;
    rd_ptr_d = rd_ptr_q + {1'b0, pop_ok};
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
    count_d = count_q + {2'b0, push_ok} - {2'b0, pop_ok};
    rx_valid = count_q != 3'd0;
    rx_byte = mem_q[rd_ptr_q];
    rx_count = count_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_q <= '{default: 8'h00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  always_comb begin
    ovr_set = push & rx_valid_q & ~pop;
    rx_valid_d = push | (rx_valid_q & ~pop);
    rx_data_d = push ? push_byte : rx_data_q;
    rx_valid = rx_valid_q;
    rx_byte = rx_data_q;
    rx_count = 3'd0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      shifter_q <= IDLE_BYTE;
      rx_sh_q <= '0;
      tx_reg_q <= IDLE_BYTE;
      tx_pending_q <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shifter_q <= shifter_d;
      rx_sh_q <= rx_sh_d;
      tx_reg_q <= tx_reg_d;
      tx_pending_q <= tx_pending_d;
      overrun_q <= overrun_d;
      irq_en_q <= irq_en_d;
    end
  assign data_out = (addr == ADDR_CTRL) ?
    {24'b0, rx_count, irq_en_q, state_q == S_SHIFT, overrun_q, tx_pending_q, rx_valid} : {24'b0, rx_byte};
  assign interrupt = irq_en_q & (rx_valid | overrun_q);
  assign spi_miso = shifter_q[7];
  assign spi_miso_oe = state_q == S_SHIFT;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized self-checking bench for spi_slave against a queue-based reference model
module tb_spi_slave;
  localparam int H = 8;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int DEPTH = 4;
  localparam bit FIFO = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit FIFO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, select, rd, addr, spi_sck, spi_ss, spi_mosi, spi_miso, spi_miso_oe, interrupt;
  logic [3:0] we;
  logic [31:0] data_in, data_out;
  int n_checks = 0, n_errors = 0;
  logic [7:0] rxq[$];
  logic m_txp, m_ovr, m_irq;
  logic [7:0] m_txr, m_next;
  spi_slave #(.CPOL(1'b1)) dut (
    .clk(clk), .reset(reset), .select(select), .rd(rd), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .interrupt(interrupt),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic m_clear();
    rxq.delete();
    m_txp = 1'b0;
    m_ovr = 1'b0;
    m_irq = 1'b0;
    m_txr = 8'hFF;
  endtask
  task automatic m_load();
    m_next = m_txp ? m_txr : 8'hFF;
    m_txp = 1'b0;
  endtask
  task automatic m_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else begin
      m_ovr = 1'b1;
      if (DEPTH == 1) rxq[0] = b;
    end
  endtask
  function automatic logic [31:0] exp_status();
    logic [2:0] c;
    c = FIFO ? 3'(rxq.size()) : 3'd0;
    return {24'b0, c, m_irq, 1'b0, m_ovr, m_txp, rxq.size() != 0};
  endfunction
  function automatic logic exp_irq();
    return m_irq & ((rxq.size() != 0) | m_ovr);
  endfunction
  task automatic cpu_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    select = 1'b1; we = 4'h1; addr = a; data_in = d;
    @(negedge clk);
    select = 1'b0; we = 4'h0;
    if (a == 1'b0) begin m_txr = d[7:0]; m_txp = 1'b1; end
    else begin m_irq = d[4]; if (d[2]) m_ovr = 1'b0; end
  endtask
  task automatic cpu_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    select = 1'b1; rd = 1'b1; addr = a;
    #1 d = data_out;
    @(negedge clk);
    select = 1'b0; rd = 1'b0;
  endtask
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      tick(H);
      mi[i] = spi_miso;
      spi_sck = 1'b0;
      tick(H);
      spi_sck = 1'b1;
    end
  endtask
  task automatic ss_down();
    spi_ss = 1'b0;
    m_load();
  endtask
  task automatic ss_up();
    tick(H);
    spi_ss = 1'b1;
    tick(H);
  endtask
  task automatic send_byte(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] em);
    spi_bits(mo, 8, mi);
    em = m_next;
    m_push(mo);
    m_load();
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_clear();
    tick(2);
  endtask
  task automatic check_status(input string nm);
    logic [31:0] d;
    cpu_read(1'b1, d);
    n_checks++;
    if (d !== exp_status()) begin n_errors++; $display("FAIL %s status got %h exp %h", nm, d, exp_status()); end
  endtask
  task automatic drain(input string nm);
    logic [31:0] d;
    while (rxq.size() != 0) begin
      cpu_read(1'b0, d);
      n_checks++;
      if (d !== {24'b0, rxq[0]}) begin n_errors++; $display("FAIL %s pop got %h exp %h", nm, d, {24'b0, rxq[0]}); end
      void'(rxq.pop_front());
    end
    cpu_write(1'b1, {27'b0, m_irq, 4'b0100});
  endtask
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_checks++;
    if (spi_miso !== 1'b1) begin n_errors++; $display("FAIL reset_miso got %b exp 1", spi_miso); end
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_errors++; $display("FAIL reset_oe got %b exp 0", spi_miso_oe); end
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b exp 0", interrupt); end
    cpu_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_status got %h exp 0", d); end
  endtask
  task automatic test_basic();
    logic [7:0] mi, em;
    cpu_write(1'b0, 32'h0000_00A5);
    ss_down();
    tick(1);
    n_checks++;
    if (spi_miso_oe !== 1'b0 && spi_miso_oe !== 1'b1) begin n_errors++; $display("FAIL basic_oe got %b exp 0/1", spi_miso_oe); end
    tick(H / 2);
    n_checks++;
    if (spi_miso_oe !== 1'b1) begin n_errors++; $display("FAIL basic_oe got %b exp 1", spi_miso_oe); end
    send_byte(8'h3C, mi, em);
    ss_up();
    n_checks++;
    if (mi !== em) begin n_errors++; $display("FAIL basic_miso got %h exp %h", mi, em); end
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_errors++; $display("FAIL basic_oe_idle got %b exp 0", spi_miso_oe); end
    check_status("basic");
    drain("basic");
  endtask
  task automatic test_idle_ff();
    logic [7:0] mi, em;
    ss_down();
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom), mi, em);
      n_checks++;
      if (mi !== em) begin n_errors++; $display("FAIL idle_ff byte%0d got %h exp %h", i, mi, em); end
    end
    ss_up();
    check_status("idle_ff");
    drain("idle_ff");
    check_status("idle_ff_clr");
  endtask
  task automatic test_abort();
    logic [7:0] mi, em;
    ss_down();
    spi_bits(8'($urandom), 5, mi);
    ss_up();
    check_status("abort");
    ss_down();
    send_byte(8'h81, mi, em);
    ss_up();
    n_checks++;
    if (mi !== em) begin n_errors++; $display("FAIL abort_miso got %h exp %h", mi, em); end
    check_status("abort_next");
    drain("abort");
  endtask
  task automatic test_irq();
    logic [7:0] mi, em;
    cpu_write(1'b1, 32'h10);
    ss_down();
    send_byte(8'h42, mi, em);
    ss_up();
    n_checks++;
    if (interrupt !== exp_irq()) begin n_errors++; $display("FAIL irq_set got %b exp %b", interrupt, exp_irq()); end
    drain("irq");
    n_checks++;
    if (interrupt !== exp_irq()) begin n_errors++; $display("FAIL irq_clr got %b exp %b", interrupt, exp_irq()); end
    cpu_write(1'b1, 32'h0);
  endtask
  task automatic test_fifo();
    logic [7:0] mi, em;
    ss_down();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), mi, em);
    ss_up();
    check_status("fifo_full");
    drain("fifo");
    check_status("fifo_clr");
  endtask
  task automatic test_random();
    logic [7:0] mi, em;
    logic [31:0] d;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1)) cpu_write(1'b0, $urandom);
      if ($urandom_range(1)) cpu_write(1'b1, $urandom);
      ss_down();
      for (int b = 0; b < int'($urandom_range(3, 1)); b++) begin
        send_byte(8'($urandom), mi, em);
        n_checks++;
        if (mi !== em) begin n_errors++; $display("FAIL rand%0d miso got %h exp %h", it, mi, em); end
      end
      ss_up();
      n_checks++;
      if (interrupt !== exp_irq()) begin n_errors++; $display("FAIL rand%0d irq got %b exp %b", it, interrupt, exp_irq()); end
      check_status("rand");
      for (int p = 0; p < int'($urandom_range(2)); p++) begin
        cpu_read(1'b0, d);
        if (rxq.size() != 0) begin
          n_checks++;
          if (d !== {24'b0, rxq[0]}) begin n_errors++; $display("FAIL rand%0d pop got %h exp %h", it, d, {24'b0, rxq[0]}); end
          void'(rxq.pop_front());
        end
      end
      check_status("rand_pop");
    end
    drain("rand");
  endtask
  task automatic test_reset_mid();
    logic [7:0] mi, em;
    cpu_write(1'b0, 32'h5A);
    cpu_write(1'b1, 32'h10);
    ss_down();
    spi_bits(8'hC3, 4, mi);
    @(negedge clk);
    addr = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (spi_miso !== 1'b1) begin n_errors++; $display("FAIL rmid_miso got %b exp 1", spi_miso); end
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_errors++; $display("FAIL rmid_oe got %b exp 0", spi_miso_oe); end
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL rmid_irq got %b exp 0", interrupt); end
    n_checks++;
    if (data_out !== 32'h0) begin n_errors++; $display("FAIL rmid_status got %h exp 0", data_out); end
    tick(2);
    reset = 1'b0;
    m_clear();
    spi_bits(8'h3C, 4, mi);
    spi_bits(8'hE7, 8, mi);
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_errors++; $display("FAIL rmid_stale_oe got %b exp 0", spi_miso_oe); end
    ss_up();
    check_status("rmid_stale");
    ss_down();
    send_byte(8'h81, mi, em);
    ss_up();
    n_checks++;
    if (mi !== em) begin n_errors++; $display("FAIL rmid_miso_next got %h exp %h", mi, em); end
    check_status("rmid_next");
    drain("rmid");
  endtask
  initial begin
    reset = 1'b1; select = 1'b0; rd = 1'b0; we = 4'h0; addr = 1'b0; data_in = 32'h0;
    spi_sck = 1'b1; spi_ss = 1'b1; spi_mosi = 1'b1;
    m_clear();
    m_next = 8'hFF;
    test_reset();
    test_basic();
    test_idle_ff();
    test_abort();
    test_irq();
    test_fifo();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
